// File: rtl/ori_ram_sched_pkg.sv
// Shared types for the CPU/video DRAM time-slot scheduler.
package ori_ram_sched_pkg;

   localparam int COL_W = 6;
   localparam int ROW_W = 8;

   typedef enum logic [1:0] {
      P_ADDR = 2'd0,
      P_RAS  = 2'd1,
      P_CAS  = 2'd2,
      P_END  = 2'd3
   } phase_t;

   typedef enum logic {
      SLOT_VID = 1'b0,
      SLOT_CPU = 1'b1
   } slot_t;

   typedef enum logic [1:0] {
      OWN_IDLE = 2'd0,
      OWN_VID  = 2'd1,
      OWN_CPU  = 2'd2
   } owner_t;

   // The slot owner gets first call; the other party may borrow an unused slot.
   function automatic owner_t pick_owner(input slot_t slot, input logic cpu_req,
                                         input logic fetch_pending);
      owner_t own;
      if (slot == SLOT_VID)
         own = fetch_pending ? OWN_VID : (cpu_req ? OWN_CPU : OWN_IDLE);
      else
         own = cpu_req ? OWN_CPU : (fetch_pending ? OWN_VID : OWN_IDLE);
      return own;
   endfunction

endpackage

// File: rtl/ori_ram_sched_if.sv
// CPU handshake plus the DRAM/address-mux control bundle of the scheduler.
interface ori_ram_sched_if;
   import ori_ram_sched_pkg::*;

   logic             cpu_req;
   logic             cpu_we;
   logic             cpu_ack;
   logic             cpu_wait;
   logic             cke_ras_n;
   logic             acc_cpu;
   logic [COL_W-1:0] num_col;
   logic [ROW_W-1:0] num_row;
   logic             ras_n;
   logic             cas_n;
   logic             we_n;
   logic             vid_strobe;

   modport master (
      output cpu_req, cpu_we,
      input  cpu_ack, cpu_wait, cke_ras_n, acc_cpu, num_col, num_row,
             ras_n, cas_n, we_n, vid_strobe
   );

   modport slave (
      input  cpu_req, cpu_we,
      output cpu_ack, cpu_wait, cke_ras_n, acc_cpu, num_col, num_row,
             ras_n, cas_n, we_n, vid_strobe
   );
endinterface

// File: rtl/ori_ram_sched_vid_cnt.sv
// Video fetch column/row counters driven by line/frame pulses and completed video cycles.
module ori_ram_sched_vid_cnt
   import ori_ram_sched_pkg::*;
#(
   parameter int COLS = 48,
   parameter int ROWS = 256
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             line_start,
   input  logic             frame_start,
   input  logic             disp_en,
   input  logic             vid_done,
   output logic [COL_W-1:0] num_col,
   output logic [ROW_W-1:0] num_row,
   output logic             fetch_pending
);

   // One extra bit so the column can rest at COLS even when COLS is 64.
   logic [COL_W:0]   col;
   logic [ROW_W-1:0] row;

   assign num_col       = col[COL_W-1:0];
   assign num_row       = row;
   assign fetch_pending = disp_en && (col < (COL_W+1)'(COLS));

   // Frame beats line, line beats a finishing fetch; column saturates at COLS.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         col <= '0;
         row <= '0;
      end else if (frame_start) begin
         col <= '0;
         row <= '0;
      end else if (line_start) begin
         col <= '0;
         row <= (row == ROW_W'(ROWS-1)) ? '0 : row + 1'b1;
      end else if (vid_done && (col < (COL_W+1)'(COLS))) begin
         col <= col + 1'b1;
      end
   end

endmodule

// File: rtl/ori_ram_sched.sv
// Four-phase DRAM cycle sequencer sharing slots between CPU and video fetch.
module ori_ram_sched
   import ori_ram_sched_pkg::*;
#(
   parameter int COLS = 48,
   parameter int ROWS = 256
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            line_start_i,
   input  logic            frame_start_i,
   input  logic            disp_en_i,
   ori_ram_sched_if.slave  bus
);

   phase_t           phase;
   slot_t            slot;
   owner_t           owner;
   owner_t           owner_pick;
   logic             cpu_wr;
   logic             fetch_pending;
   logic             vid_done;
   logic             ras_n;
   logic             cas_n;
   logic             we_n;
   logic             vid_strobe;
   logic             cpu_ack;
   logic [COL_W-1:0] num_col;
   logic [ROW_W-1:0] num_row;

   // The owner is chosen from live inputs during P_ADDR so a request present
   // that clock is served; the mux strobe and owner flag drop with reset at once.
   assign owner_pick     = pick_owner(slot, bus.cpu_req, fetch_pending);
   assign bus.cke_ras_n  = rst_n_i && (phase == P_ADDR);
   assign bus.acc_cpu    = rst_n_i && ((phase == P_ADDR) ? (owner_pick == OWN_CPU)
                                                         : (owner == OWN_CPU));
   assign bus.cpu_wait   = bus.cpu_req && !cpu_ack;
   assign bus.ras_n      = ras_n;
   assign bus.cas_n      = cas_n;
   assign bus.we_n       = we_n;
   assign bus.vid_strobe = vid_strobe;
   assign bus.cpu_ack    = cpu_ack;
   assign bus.num_col    = num_col;
   assign bus.num_row    = num_row;
   assign vid_done       = (phase == P_END) && (owner == OWN_VID);

   ori_ram_sched_vid_cnt #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_vid_cnt (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .line_start    (line_start_i),
      .frame_start   (frame_start_i),
      .disp_en       (disp_en_i),
      .vid_done      (vid_done),
      .num_col       (num_col),
      .num_row       (num_row),
      .fetch_pending (fetch_pending)
   );

   // Phase sequencer: each edge sets up the DRAM strobes for the phase being entered.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         phase      <= P_ADDR;
         slot       <= SLOT_VID;
         owner      <= OWN_IDLE;
         cpu_wr     <= 1'b0;
         ras_n      <= 1'b1;
         cas_n      <= 1'b1;
         we_n       <= 1'b1;
         vid_strobe <= 1'b0;
         cpu_ack    <= 1'b0;
      end else begin
         case (phase)
            P_ADDR: begin
               phase  <= P_RAS;
               owner  <= owner_pick;
               cpu_wr <= bus.cpu_we && (owner_pick == OWN_CPU);
               ras_n  <= (owner_pick == OWN_IDLE);
            end
            P_RAS: begin
               phase <= P_CAS;
               cas_n <= (owner == OWN_IDLE);
               we_n  <= !cpu_wr;
            end
            P_CAS: begin
               phase      <= P_END;
               we_n       <= 1'b1;
               vid_strobe <= (owner == OWN_VID);
               cpu_ack    <= (owner == OWN_CPU);
            end
            P_END: begin
               phase      <= P_ADDR;
               slot       <= (slot == SLOT_VID) ? SLOT_CPU : SLOT_VID;
               owner      <= OWN_IDLE;
               cpu_wr     <= 1'b0;
               ras_n      <= 1'b1;
               cas_n      <= 1'b1;
               vid_strobe <= 1'b0;
               cpu_ack    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ori_ram_sched.sv
// Scoreboard bench for ori_ram_sched: driver predicts every slot, monitor checks the DUT.
module tb_ori_ram_sched;

   localparam int COLS = 48;
   localparam int ROWS = 256;
   localparam int IDLE = 0;
   localparam int VID  = 1;
   localparam int CPU  = 2;

   typedef struct {
      int owner;
      int col;
      int row;
      bit wr;
   } slot_exp_t;

   typedef struct {
      int owner;
      int due;
   } done_exp_t;

   logic clk_i = 1'b0;
   logic rst_n_i = 1'b0;
   logic line_start_i = 1'b0;
   logic frame_start_i = 1'b0;
   logic disp_en_i = 1'b0;

   ori_ram_sched_if bus ();

   ori_ram_sched #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .line_start_i  (line_start_i),
      .frame_start_i (frame_start_i),
      .disp_en_i     (disp_en_i),
      .bus           (bus)
   );

   always #5 clk_i = ~clk_i;

   int        total = 0;
   int        bad = 0;
   int        k = 0;
   bit        mon_en = 0;
   slot_exp_t addr_q[$];
   done_exp_t done_q[$];

   // reference model state
   int col = 0;
   int row = 0;
   int cur_owner = IDLE;
   int ack_due = -1;
   bit req = 0;
   bit we = 0;
   bit disp = 0;
   bit line_pend = 0;
   bit frame_pend = 0;
   bit rand_mode = 0;

   // monitor state
   slot_exp_t prev;
   bit        have_prev = 0;
   int        ras_cnt = 0;
   int        cas_cnt = 0;
   int        we_cnt = 0;
   int        vid_cnt = 0;

   task automatic checkOutput(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, k);
      end
   endtask

   // Drives n clocks; on each P_ADDR the model predicts the slot and queues expectations.
   task automatic applyStimulus(input int n);
      int  ph;
      int  own;
      bit  pend;
      for (int i = 0; i < n; i++) begin
         ph = k % 4;
         if (rand_mode) begin
            if (req) begin
               if (ack_due >= 0 && k == ack_due + 1) begin
                  ack_due = -1;
                  if ($urandom_range(0, 1) == 1) we = 1'($urandom_range(0, 1));
                  else req = 0;
               end
            end else if ($urandom_range(0, 3) == 0) begin
               req = 1;
               we  = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 63) == 0) disp = !disp;
            if ($urandom_range(0, 99) == 0) line_pend = 1;
            if ($urandom_range(0, 1499) == 0) frame_pend = 1;
         end
         bus.cpu_req   = req;
         bus.cpu_we    = we;
         disp_en_i     = disp;
         line_start_i  = line_pend;
         frame_start_i = frame_pend;
         if (ph == 0) begin
            pend = disp && (col < COLS);
            if (((k / 4) % 2) == 0) own = pend ? VID : (req ? CPU : IDLE);
            else                    own = req ? CPU : (pend ? VID : IDLE);
            cur_owner = own;
            addr_q.push_back('{own, col, row, (own == CPU) && we});
            if (own != IDLE) done_q.push_back('{own, k + 3});
            if (own == CPU) ack_due = k + 3;
         end
         if (frame_pend) begin
            col = 0;
            row = 0;
         end else if (line_pend) begin
            col = 0;
            row = (row + 1) % ROWS;
         end else if (ph == 3 && cur_owner == VID && col < COLS) begin
            col++;
         end
         line_pend  = 0;
         frame_pend = 0;
         @(posedge clk_i);
         k++;
         #1;
      end
   endtask

   // Monitor: checks each mux latch and each completion strobe against the queues.
   always @(negedge clk_i) begin
      if (!rst_n_i) begin
         have_prev = 0;
         ras_cnt = 0;
         cas_cnt = 0;
         we_cnt = 0;
      end else if (mon_en) begin
         if (bus.cke_ras_n) begin
            if (have_prev) begin
               checkOutput("ras_low_clocks", ras_cnt, (prev.owner == IDLE) ? 0 : 3);
               checkOutput("cas_low_clocks", cas_cnt, (prev.owner == IDLE) ? 0 : 2);
               checkOutput("we_low_clocks", we_cnt, prev.wr ? 1 : 0);
            end
            if (addr_q.size() == 0) begin
               checkOutput("unexpected_cke", 1, 0);
               have_prev = 0;
            end else begin
               prev = addr_q.pop_front();
               have_prev = 1;
               checkOutput("acc_cpu", int'(bus.acc_cpu), (prev.owner == CPU) ? 1 : 0);
               if (prev.owner == VID) begin
                  checkOutput("num_col", int'(bus.num_col), prev.col);
                  checkOutput("num_row", int'(bus.num_row), prev.row);
               end
            end
            ras_cnt = 0;
            cas_cnt = 0;
            we_cnt = 0;
         end
         ras_cnt += int'(!bus.ras_n);
         cas_cnt += int'(!bus.cas_n);
         we_cnt  += int'(!bus.we_n);
         if (bus.vid_strobe) vid_cnt++;
         if (bus.vid_strobe && bus.cpu_ack) begin
            checkOutput("both_strobes", 1, 0);
         end else if (bus.vid_strobe || bus.cpu_ack) begin
            if (done_q.size() == 0) begin
               checkOutput("unexpected_strobe", bus.cpu_ack ? CPU : VID, IDLE);
            end else begin
               done_exp_t d;
               d = done_q.pop_front();
               checkOutput("done_kind", bus.cpu_ack ? CPU : VID, d.owner);
               checkOutput("done_clock", k, d.due);
            end
         end
      end
   end

   initial begin
      repeat (60000) @(posedge clk_i);
      $display("[TB] FAIL watchdog: cycle budget exhausted at cycle %0d", k);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int guard;
      int vid_before;
      bus.cpu_req = 1'b0;
      bus.cpu_we  = 1'b0;

      // reset state
      repeat (3) @(posedge clk_i);
      #1;
      checkOutput("rst_ras_n", int'(bus.ras_n), 1);
      checkOutput("rst_cas_n", int'(bus.cas_n), 1);
      checkOutput("rst_we_n", int'(bus.we_n), 1);
      checkOutput("rst_cke", int'(bus.cke_ras_n), 0);
      checkOutput("rst_acc_cpu", int'(bus.acc_cpu), 0);
      checkOutput("rst_ack", int'(bus.cpu_ack), 0);
      checkOutput("rst_vid_strobe", int'(bus.vid_strobe), 0);
      checkOutput("rst_col", int'(bus.num_col), 0);
      checkOutput("rst_row", int'(bus.num_row), 0);
      rst_n_i = 1'b1;
      k = 0;
      mon_en = 1;

      $display("[TB] idle cycles, display off");
      applyStimulus(16);

      $display("[TB] one line of video fetch");
      vid_before = vid_cnt;
      disp = 1;
      line_pend = 1;
      applyStimulus(48 * 4 + 24);
      checkOutput("line_fetch_count", vid_cnt - vid_before, 48);
      checkOutput("col_saturated", int'(bus.num_col), 48);
      checkOutput("row_after_line", int'(bus.num_row), 1);

      $display("[TB] CPU writes held with video fetching");
      req = 1;
      we = 1;
      line_pend = 1;
      applyStimulus(64);
      req = 0;
      applyStimulus(8);

      $display("[TB] line pulse on video P_END");
      line_pend = 1;
      applyStimulus(1);
      guard = 0;
      while (!(k % 4 == 3 && cur_owner == VID && col == 10) && guard < 400) begin
         applyStimulus(1);
         guard++;
      end
      checkOutput("reach_col10", guard < 400 ? 1 : 0, 1);
      line_pend = 1;
      applyStimulus(1);
      checkOutput("col_after_line_on_end", int'(bus.num_col), col);
      checkOutput("row_after_line_on_end", int'(bus.num_row), row);
      guard = 0;
      while (!(k % 4 == 3 && cur_owner == VID && col > 0) && guard < 400) begin
         applyStimulus(1);
         guard++;
      end
      line_pend = 1;
      frame_pend = 1;
      applyStimulus(1);
      checkOutput("col_after_frame", int'(bus.num_col), 0);
      checkOutput("row_after_frame", int'(bus.num_row), 0);

      $display("[TB] row wrap");
      guard = 0;
      while (row != ROWS - 1 && guard < 400) begin
         line_pend = 1;
         applyStimulus(1);
         guard++;
      end
      checkOutput("row_at_max", int'(bus.num_row), 255);
      line_pend = 1;
      applyStimulus(1);
      checkOutput("row_wrapped", int'(bus.num_row), 0);

      $display("[TB] single CPU read then drop");
      disp = 0;
      applyStimulus(8);
      while (k % 4 != 0) applyStimulus(1);
      req = 1;
      we = 0;
      applyStimulus(1);
      req = 0;
      applyStimulus(16);

      $display("[TB] randomized traffic");
      ack_due = -1;
      rand_mode = 1;
      applyStimulus(2000);
      rand_mode = 0;

      $display("[TB] reset during CPU write");
      disp = 0;
      req = 1;
      we = 1;
      applyStimulus(1);
      guard = 0;
      while (!(k % 4 == 2 && cur_owner == CPU) && guard < 64) begin
         applyStimulus(1);
         guard++;
      end
      checkOutput("pre_reset_we_n", int'(bus.we_n), 0);
      rst_n_i = 1'b0;
      #1;
      checkOutput("async_ras_n", int'(bus.ras_n), 1);
      checkOutput("async_cas_n", int'(bus.cas_n), 1);
      checkOutput("async_we_n", int'(bus.we_n), 1);
      req = 0;
      we = 0;
      bus.cpu_req = 1'b0;
      bus.cpu_we = 1'b0;
      addr_q.delete();
      done_q.delete();
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      k = 0;
      col = 0;
      row = 0;
      cur_owner = IDLE;
      ack_due = -1;
      applyStimulus(24);
      checkOutput("done_q_drained", done_q.size(), 0);
      checkOutput("addr_q_drained", addr_q.size(), 0);

      $display("[TB] test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
